// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
//   Shared types and the seven-segment decoder for the display scan driver.
//   Contents:
//     seg7_t      7-bit segment vector {a,b,c,d,e,f,g}, active-low
//     SEG_BLANK   all segments dark
//     seg_decode  nibble -> segment pattern. Codes A-F are shown only when
//                 hex_en is set and are dark otherwise.
// -----------------------------------------------------------------------------
package sseg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;

    function automatic seg7_t seg_decode(input logic [3:0] code, input bit hex_en);
        seg7_t seg;
        seg = SEG_BLANK;
        case (code)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: if (hex_en) seg = 7'h08;
            4'hB: if (hex_en) seg = 7'h60;
            4'hC: if (hex_en) seg = 7'h31;
            4'hD: if (hex_en) seg = 7'h42;
            4'hE: if (hex_en) seg = 7'h30;
            4'hF: if (hex_en) seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// -----------------------------------------------------------------------------
// sseg_scan_timer
//   Generates the scan timing for the display driver. A prescaler selects each
//   digit for SCAN_DIV cycles. The digit index advances when the prescaler
//   wraps.
//   Ports:
//     clk           system clock, rising edge
//     rst           synchronous, active-high reset
//     en_i          scan enable; 0 holds prescaler and index at 0
//     index_o       digit currently selected
//     gap_o         prescaler is inside the anti-ghost window after a switch
//     frame_tick_o  index wraps to 0 on the coming edge (frame boundary)
// -----------------------------------------------------------------------------
module sseg_scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [IDX_W-1:0] index_o,
    output logic             gap_o,
    output logic             frame_tick_o
);

    localparam int               PRE_W    = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             pre_wrap;

    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        prescaler_d = prescaler_q;
        index_d     = index_q;
        pre_wrap    = en_i && (prescaler_q == PRE_LAST);
        if (!en_i) begin
            prescaler_d = '0;
            index_d     = '0;
        end else if (pre_wrap) begin
            prescaler_d = '0;
            index_d     = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end else begin
            prescaler_d = prescaler_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            index_q     <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            index_q     <= index_d;
        end
    end

    // The anodes stay off for the first BLANK_CYC prescaler counts of each digit.
    generate
        if (BLANK_CYC == 0) begin : g_no_gap
            assign gap_o = 1'b0;
        end else begin : g_gap
            assign gap_o = (prescaler_q < PRE_W'(BLANK_CYC));
        end
    endgenerate

    assign index_o      = index_q;
    assign frame_tick_o = pre_wrap && (index_q == IDX_LAST);

endmodule

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   A load captures the digits into a shadow register. The shadow register is
//   copied to the display register only at a frame boundary, so a frame never
//   shows a mix of old and new digits.
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous, active-high reset
//     en_i       scan enable; 0 = display dark
//     load_i     strobe: capture digits_i / dp_i
//     digits_i   nibble k = digit k, k=0 rightmost
//     dp_i       decimal point per digit, 1 = lit
//     lzb_i      1 = blank leading zeros
//     seg_o      {a,b,c,d,e,f,g}, active-low
//     dp_o       decimal point, active-low
//     an_o       one-hot digit select, polarity set by AN_ACT_LOW
//     frame_o    1-cycle pulse when the scan index wraps to 0
// -----------------------------------------------------------------------------
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 2,
    parameter int HEX_EN     = 0,
    parameter int AN_ACT_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    lzb_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int                    IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

    logic [IDX_W-1:0] index;
    logic             gap;
    logic             frame_tick;

    sseg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .index_o      (index),
        .gap_o        (gap),
        .frame_tick_o (frame_tick)
    );

    // ------------------------------------------------------------------
    // Shadow / display registers
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

    always_comb begin
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;
        if (load_i) begin
            shadow_dig_d = digits_i;
            shadow_dp_d  = dp_i;
            pending_d    = 1'b1;
        end
        if (frame_tick) begin
            // A load on the boundary itself goes straight to the display.
            // It overrides anything pending and leaves nothing pending.
            if (load_i) begin
                disp_dig_d = digits_i;
                disp_dp_d  = dp_i;
                pending_d  = 1'b0;
            end else if (pending_q) begin
                disp_dig_d = shadow_dig_q;
                disp_dp_d  = shadow_dp_q;
                pending_d  = 1'b0;
            end
        end
    end

    // NOTE: shadow and display are small flop registers, not a RAM. They take the reset so that stale data can never reach the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
        end else begin
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: digit k is blanked when it and every digit to its
    // left are zero. Digit 0 always shows.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  zero_run;

    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_dig_q[4*k +: 4] == 4'h0);
            if (k > 0) lz_blank[k] = lzb_i && zero_run;
        end
    end

    // ------------------------------------------------------------------
    // Digit mux
    // ------------------------------------------------------------------
    logic [3:0]            cur_code;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] sel_onehot;

    always_comb begin
        cur_code   = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (index == IDX_W'(k)) begin
                cur_code      = disp_dig_q[4*k +: 4];
                cur_dp        = disp_dp_q[k];
                cur_blank     = lz_blank[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: the pins lag the index by one cycle. The segments
    // already hold the next digit during the anode gap, so they are settled
    // before the anode turns on.
    // ------------------------------------------------------------------
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    always_comb begin
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = AN_OFF;
        frame_d = frame_tick;
        if (en_i) begin
            seg_d = cur_blank ? SEG_BLANK : seg_decode(cur_code, HEX_EN != 0);
            dp_d  = ~cur_dp;
            if (!gap) an_d = (AN_ACT_LOW != 0) ? ~sel_onehot : sel_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//   Two drivers (HEX_EN=0 and HEX_EN=1) share every input. Expected digit
//   strobes go into a scoreboard queue. Each digit entry is popped when an
//   anode becomes active.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int ND = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic          lzb;
    logic [15:0]   digits;
    logic [3:0]    dps;

    logic [6:0]    seg0, seg1;
    logic          dpo0, dpo1;
    logic [3:0]    an0, an1;
    logic          frame0, frame1;

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .NUM_DIGITS (ND), .SCAN_DIV (4), .BLANK_CYC (1), .HEX_EN (0), .AN_ACT_LOW (1)
    ) dut_dec (
        .clk (clk), .rst (rst), .en_i (en), .load_i (load), .digits_i (digits),
        .dp_i (dps), .lzb_i (lzb), .seg_o (seg0), .dp_o (dpo0), .an_o (an0),
        .frame_o (frame0)
    );

    sseg_scan_driver #(
        .NUM_DIGITS (ND), .SCAN_DIV (4), .BLANK_CYC (1), .HEX_EN (1), .AN_ACT_LOW (1)
    ) dut_hex (
        .clk (clk), .rst (rst), .en_i (en), .load_i (load), .digits_i (digits),
        .dp_i (dps), .lzb_i (lzb), .seg_o (seg1), .dp_o (dpo1), .an_o (an1),
        .frame_o (frame1)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg_dec;
        logic [6:0] seg_hex;
        logic       dp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] c, input bit hex);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'h01;  4'h1: s = 7'h4F;  4'h2: s = 7'h12;  4'h3: s = 7'h06;
            4'h4: s = 7'h4C;  4'h5: s = 7'h24;  4'h6: s = 7'h20;  4'h7: s = 7'h0F;
            4'h8: s = 7'h00;  4'h9: s = 7'h04;
            4'hA: s = hex ? 7'h08 : 7'h7F;
            4'hB: s = hex ? 7'h60 : 7'h7F;
            4'hC: s = hex ? 7'h31 : 7'h7F;
            4'hD: s = hex ? 7'h42 : 7'h7F;
            4'hE: s = hex ? 7'h30 : 7'h7F;
            default: s = hex ? 7'h38 : 7'h7F;
        endcase
        return s;
    endfunction

    // Queue the expected strobe of digit k for display word w.
    task automatic push_digit(input logic [15:0] w, input logic [3:0] d, input logic lz, input int k);
        exp_t       e;
        bit         run;
        logic [3:0] nib;
        run = 1'b1;
        for (int j = ND - 1; j >= k; j--) begin
            nib = w[4*j +: 4];
            run = run && (nib == 4'h0);
        end
        nib       = w[4*k +: 4];
        e.an      = 4'hF;
        e.an[k]   = 1'b0;
        e.seg_dec = (lz && run && k != 0) ? 7'h7F : ref_seg(nib, 1'b0);
        e.seg_hex = (lz && run && k != 0) ? 7'h7F : ref_seg(nib, 1'b1);
        e.dp      = ~d[k];
        sb_q.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] w, input logic [3:0] d);
        digits = w;
        dps    = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"},   seg0,   7'h7F);
        check({tag, "_dp"},    dpo0,   1'b1);
        check({tag, "_an"},    an0,    4'hF);
        check({tag, "_frame"}, frame0, 1'b0);
    endtask

    // Returns at a negedge where frame_o is high. Gives up after a cycle budget.
    task automatic wait_frame(input string tag);
        int i;
        i = 0;
        while (frame0 !== 1'b1 && i < 64) begin
            @(negedge clk);
            i++;
        end
        if (frame0 !== 1'b1) check({tag, "_frame_timeout"}, 0, 1);
    endtask

    // Watch n cycles. Pop one scoreboard entry each time a new anode turns on.
    task automatic watch_digits(input string tag, input int n, input bit duty);
        logic [3:0] prev;
        int         cnt[ND];
        exp_t       e;
        prev = 4'hF;
        for (int k = 0; k < ND; k++) cnt[k] = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (an0 != 4'hF) begin
                for (int k = 0; k < ND; k++) if (!an0[k]) cnt[k]++;
                if (an0 != prev) begin
                    if (sb_q.size() == 0) begin
                        check({tag, "_extra_digit"}, an0, 4'hF);
                    end else begin
                        e = sb_q.pop_front();
                        check({tag, "_an"},     an0,  e.an);
                        check({tag, "_an_hex"}, an1,  e.an);
                        check({tag, "_seg"},    seg0, e.seg_dec);
                        check({tag, "_seg_hex"},seg1, e.seg_hex);
                        check({tag, "_dp"},     dpo0, e.dp);
                    end
                end
            end
            prev = an0;
        end
        if (sb_q.size() != 0) begin
            check({tag, "_missing_digits"}, sb_q.size(), 0);
            sb_q.delete();
        end
        if (duty) for (int k = 0; k < ND; k++) check({tag, "_duty"}, cnt[k], 3);
    endtask

    task automatic expect_frame(input string tag, input logic [15:0] w, input logic [3:0] d,
                                input bit duty);
        for (int k = 0; k < ND; k++) push_digit(w, d, lzb, k);
        wait_frame(tag);
        watch_digits(tag, 16, duty);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; lzb = 1'b0; digits = '0; dps = '0;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check_dark("reset");
        end
        rst = 1'b0;
        en  = 1'b1;

        // Basic scan with duty cycle.
        do_load(16'h1234, 4'b0000);
        expect_frame("scan_1234", 16'h1234, 4'b0000, 1'b1);

        // Leading-zero blanking. The dp of a blanked digit stays lit.
        lzb = 1'b1;
        do_load(16'h0050, 4'b0010);
        expect_frame("lzb_0050", 16'h0050, 4'b0010, 1'b0);
        do_load(16'h0000, 4'b1000);
        expect_frame("lzb_0000", 16'h0000, 4'b1000, 1'b0);
        lzb = 1'b0;

        // Hex codes on both instances.
        do_load(16'hABCD, 4'b1000);
        expect_frame("hex_abcd", 16'hABCD, 4'b1000, 1'b0);

        // Two loads inside one frame: the last one wins.
        wait_frame("sync5");
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0001);
        expect_frame("last_wins", 16'h2222, 4'b0001, 1'b0);

        // A load in the boundary cycle bypasses the shadow register.
        wait_frame("sync_bypass");
        repeat (15) @(negedge clk);
        do_load(16'h5678, 4'b0101);
        expect_frame("bypass", 16'h5678, 4'b0101, 1'b0);

        // Disable mid-scan, load while dark, then re-enable.
        wait_frame("sync6");
        repeat (5) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_dark("en_low0");
        do_load(16'h9876, 4'b0000);
        check_dark("en_low1");
        @(negedge clk);
        check_dark("en_low2");
        en = 1'b1;
        push_digit(16'h5678, 4'b0101, lzb, 0);
        watch_digits("restart", 5, 1'b0);
        expect_frame("pend_after_en", 16'h9876, 4'b0000, 1'b0);

        // Reset mid-frame with a load still pending: the load is discarded.
        wait_frame("sync7");
        repeat (4) @(negedge clk);
        do_load(16'h4321, 4'b1111);
        rst = 1'b1;
        @(negedge clk);
        check_dark("rst_mid");
        rst = 1'b0;
        expect_frame("after_rst", 16'h0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
